// File: rtl/collision_probe_pkg.sv
// rtl/collision_probe_pkg.sv - shared encodings, geometry defaults and FSM state type
package collision_probe_pkg;

    localparam int CAR_W_DEF = 32;
    localparam int CAR_H_DEF = 32;
    localparam int X_MAX_DEF = 639;
    localparam int Y_MAX_DEF = 479;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_PROBE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/collision_probe_probe_target.sv
// rtl/collision_probe_probe_target.sv - combinational move target with border clamping
//
// Ports:
//   cur_x, cur_y : current top-left pixel
//   dir, step    : move direction and distance
//   tx, ty       : clamped target top-left pixel
module probe_target
    import collision_probe_pkg::*;
#(
    parameter int X_LIM = 608,
    parameter int Y_LIM = 448
) (
    input  logic [9:0] cur_x,
    input  logic [9:0] cur_y,
    input  logic [1:0] dir,
    input  logic [3:0] step,
    output logic [9:0] tx,
    output logic [9:0] ty
);

    localparam logic [10:0] X_LIM_W = 11'(X_LIM);
    localparam logic [10:0] Y_LIM_W = 11'(Y_LIM);
    localparam logic [9:0]  X_LIM_N = 10'(X_LIM);
    localparam logic [9:0]  Y_LIM_N = 10'(Y_LIM);

    logic [10:0] sum_x;
    logic [10:0] sum_y;
    logic [10:0] dif_x;
    logic [10:0] dif_y;

    // 11-bit arithmetic: bit 10 of a difference flags an underflow.
    always_comb begin
        sum_x = {1'b0, cur_x} + {7'b0, step};
        sum_y = {1'b0, cur_y} + {7'b0, step};
        dif_x = {1'b0, cur_x} - {7'b0, step};
        dif_y = {1'b0, cur_y} - {7'b0, step};
        tx    = cur_x;
        ty    = cur_y;
        case (dir)
            DIR_UP:    ty = dif_y[10] ? 10'd0 : dif_y[9:0];
            DIR_DOWN:  ty = (sum_y > Y_LIM_W) ? Y_LIM_N : sum_y[9:0];
            DIR_LEFT:  tx = dif_x[10] ? 10'd0 : dif_x[9:0];
            default:   tx = (sum_x > X_LIM_W) ? X_LIM_N : sum_x[9:0];
        endcase
    end

endmodule

// File: rtl/collision_probe.sv
// rtl/collision_probe.sv - probes the four car corners at a move target against the map
//
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req_valid / req_ready       : move request handshake (ready only when idle)
//   cur_x, cur_y, dir, step     : request payload, latched at acceptance
//   level_id                    : active level, latched at acceptance
//   probe_x, probe_y, probe_level / probe_is_wall : external map query and answer
//   rsp_valid, rsp_blocked      : one-cycle result strobe and wall hit flag
//   new_x, new_y                : resolved position, held between responses
module collision_probe
    import collision_probe_pkg::*;
#(
    parameter int CAR_W = CAR_W_DEF,
    parameter int CAR_H = CAR_H_DEF,
    parameter int X_MAX = X_MAX_DEF,
    parameter int Y_MAX = Y_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [9:0] cur_x,
    input  logic [9:0] cur_y,
    input  logic [1:0] dir,
    input  logic [3:0] step,
    input  logic [1:0] level_id,
    output logic [9:0] probe_x,
    output logic [9:0] probe_y,
    output logic [1:0] probe_level,
    input  logic       probe_is_wall,
    output logic       rsp_valid,
    output logic       rsp_blocked,
    output logic [9:0] new_x,
    output logic [9:0] new_y
);

    localparam logic [9:0] OFF_X = 10'(CAR_W - 1);
    localparam logic [9:0] OFF_Y = 10'(CAR_H - 1);

    state_t     state_q, state_d;
    logic [1:0] corner_q, corner_d;
    logic       blocked_q, blocked_d;
    logic [9:0] cur_x_q, cur_x_d;
    logic [9:0] cur_y_q, cur_y_d;
    logic [1:0] dir_q, dir_d;
    logic [3:0] step_q, step_d;
    logic [1:0] level_q, level_d;
    logic [9:0] new_x_q, new_x_d;
    logic [9:0] new_y_q, new_y_d;
    logic [9:0] tx;
    logic [9:0] ty;

    probe_target #(
        .X_LIM(X_MAX - CAR_W + 1),
        .Y_LIM(Y_MAX - CAR_H + 1)
    ) u_target (
        .cur_x(cur_x_q),
        .cur_y(cur_y_q),
        .dir  (dir_q),
        .step (step_q),
        .tx   (tx),
        .ty   (ty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            corner_q  <= 2'd0;
            blocked_q <= 1'b0;
            cur_x_q   <= 10'd0;
            cur_y_q   <= 10'd0;
            dir_q     <= 2'd0;
            step_q    <= 4'd0;
            level_q   <= 2'd0;
            new_x_q   <= 10'd0;
            new_y_q   <= 10'd0;
        end else begin
            state_q   <= state_d;
            corner_q  <= corner_d;
            blocked_q <= blocked_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            level_q   <= level_d;
            new_x_q   <= new_x_d;
            new_y_q   <= new_y_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        corner_d    = corner_q;
        blocked_d   = blocked_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        dir_d       = dir_q;
        step_d      = step_q;
        level_d     = level_q;
        new_x_d     = new_x_q;
        new_y_d     = new_y_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_blocked = 1'b0;
        probe_x     = 10'd0;
        probe_y     = 10'd0;
        probe_level = 2'd0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cur_x_d   = cur_x;
                    cur_y_d   = cur_y;
                    dir_d     = dir;
                    step_d    = step;
                    level_d   = level_id;
                    blocked_d = 1'b0;
                    corner_d  = 2'd0;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: state_d = ST_PROBE;
            ST_PROBE: begin
                // Corner bit 0 selects the right edge, bit 1 the bottom edge.
                probe_level = level_q;
                probe_x     = corner_q[0] ? (tx + OFF_X) : tx;
                probe_y     = corner_q[1] ? (ty + OFF_Y) : ty;
                blocked_d   = blocked_q | probe_is_wall;
                corner_d    = corner_q + 2'd1;
                if (corner_q == 2'd3) begin
                    // Resolve position here so it is already stable during RESP.
                    new_x_d = blocked_d ? cur_x_q : tx;
                    new_y_d = blocked_d ? cur_y_q : ty;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid   = 1'b1;
                rsp_blocked = blocked_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign new_x = new_x_q;
    assign new_y = new_y_q;

endmodule

// File: tb/tb_collision_probe.sv
// tb/tb_collision_probe.sv - directed self-checking bench for collision_probe
module tb_collision_probe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [9:0] cur_x, cur_y;
    logic [1:0] dir;
    logic [3:0] step;
    logic [1:0] level_id;
    logic [9:0] probe_x, probe_y;
    logic [1:0] probe_level;
    logic       probe_is_wall;
    logic       rsp_valid, rsp_blocked;
    logic [9:0] new_x, new_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    collision_probe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .cur_x        (cur_x),
        .cur_y        (cur_y),
        .dir          (dir),
        .step         (step),
        .level_id     (level_id),
        .probe_x      (probe_x),
        .probe_y      (probe_y),
        .probe_level  (probe_level),
        .probe_is_wall(probe_is_wall),
        .rsp_valid    (rsp_valid),
        .rsp_blocked  (rsp_blocked),
        .new_x        (new_x),
        .new_y        (new_y)
    );

    // 32-pixel tile map: border on every level, level 1 adds column gx=10.
    always_comb begin
        probe_is_wall = (probe_x / 32 == 0) || (probe_x / 32 == 19) ||
                        (probe_y / 32 == 0) || (probe_y / 32 == 14) ||
                        ((probe_level == 2'd1) && (probe_x / 32 == 10));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_req(input logic [1:0] lvl, input logic [9:0] x, input logic [9:0] y,
                           input logic [1:0] d, input logic [3:0] st,
                           input logic [9:0] etx, input logic [9:0] ety, input logic eb);
        logic [9:0] cx [4];
        logic [9:0] cy [4];
        cx[0] = etx;       cy[0] = ety;
        cx[1] = etx + 31;  cy[1] = ety;
        cx[2] = etx;       cy[2] = ety + 31;
        cx[3] = etx + 31;  cy[3] = ety + 31;
        chk("idle_ready", req_ready, 1);
        level_id = lvl; cur_x = x; cur_y = y; dir = d; step = st; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs so the result depends on the latched copy only.
        req_valid = 1'b0; cur_x = 10'd0; cur_y = 10'd0; step = 4'd0; level_id = 2'd3;
        chk("calc_ready", req_ready, 0);
        chk("calc_probe", {probe_x, probe_y}, 0);
        chk("calc_rsp", rsp_valid, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("probe", {probe_level, probe_x, probe_y}, {lvl, cx[c], cy[c]});
            chk("probe_rsp", rsp_valid, 0);
        end
        @(negedge clk);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_blocked", rsp_blocked, eb);
        chk("new_xy", {new_x, new_y}, eb ? {x, y} : {etx, ety});
        @(negedge clk);
        chk("post_rsp_valid", {rsp_valid, rsp_blocked}, 0);
        chk("post_ready", req_ready, 1);
        chk("hold_new_xy", {new_x, new_y}, eb ? {x, y} : {etx, ety});
    endtask

    initial begin
        int accepts;
        int rsps;
        int acc_at [$];
        int rsp_at [$];
        logic saw_rsp;

        rst_n = 1'b0; req_valid = 1'b0; cur_x = 0; cur_y = 0; dir = 0; step = 0; level_id = 0;
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_outs", {probe_x, probe_y, probe_level, rsp_valid, rsp_blocked, new_x, new_y}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_req(2'd1, 10'd280, 10'd200, 2'd3, 4'd8,  10'd288, 10'd200, 1'b0);
        run_req(2'd1, 10'd280, 10'd200, 2'd3, 4'd9,  10'd289, 10'd200, 1'b1);
        run_req(2'd0, 10'd32,  10'd32,  2'd2, 4'd4,  10'd28,  10'd32,  1'b1);
        run_req(2'd0, 10'd600, 10'd200, 2'd3, 4'd15, 10'd608, 10'd200, 1'b1);
        run_req(2'd0, 10'd200, 10'd3,   2'd0, 4'd8,  10'd200, 10'd0,   1'b1);
        run_req(2'd0, 10'd100, 10'd100, 2'd1, 4'd5,  10'd100, 10'd105, 1'b0);
        run_req(2'd1, 10'd100, 10'd100, 2'd1, 4'd0,  10'd100, 10'd100, 1'b0);
        run_req(2'd2, 10'd100, 10'd440, 2'd1, 4'd15, 10'd100, 10'd448, 1'b1);

        // Reset during corner 2.
        level_id = 2'd1; cur_x = 10'd280; cur_y = 10'd200; dir = 2'd3; step = 4'd8;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_corner2", {probe_x, probe_y}, {10'd288, 10'd231});
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", req_ready, 1);
        chk("midrst_outs", {probe_x, probe_y, probe_level, rsp_valid, rsp_blocked, new_x, new_y}, 0);
        saw_rsp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_rsp = saw_rsp | rsp_valid;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            saw_rsp = saw_rsp | rsp_valid;
        end
        chk("midrst_no_rsp", saw_rsp, 0);
        run_req(2'd1, 10'd280, 10'd200, 2'd3, 4'd8, 10'd288, 10'd200, 1'b0);

        // Back-to-back: req_valid held high across 21 sampled cycles.
        accepts = 0; rsps = 0;
        level_id = 2'd1; cur_x = 10'd100; cur_y = 10'd100; dir = 2'd3; step = 4'd1;
        req_valid = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (req_ready) begin accepts++; acc_at.push_back(i); end
            if (rsp_valid) begin rsps++; rsp_at.push_back(i); end
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("stream_accepts", accepts, 3);
        chk("stream_rsps", rsps, 3);
        if (acc_at.size() == 3 && rsp_at.size() == 3) begin
            chk("stream_acc_gap", acc_at[2] - acc_at[0], 14);
            chk("stream_rsp_lat", rsp_at[0] - acc_at[0], 6);
        end else begin
            chk("stream_queue_size", acc_at.size() + rsp_at.size(), 6);
        end
        chk("stream_new_xy", {new_x, new_y}, {10'd101, 10'd100});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
